// File: rtl/data_deserializer.sv
// Serial-to-byte deserializer for sensor readout: packs data_in bits into
// bytes, writes them to a FIFO, pads a trailing partial byte with zeros.
module data_deserializer #(
   parameter int CNT_W     = 16,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk_5,
   input  logic             Reset,
   input  logic             data_in,
   input  logic             start,
   input  logic [CNT_W-1:0] nbits,
   input  logic             abort,
   input  logic             fifo_full,
   output logic [7:0]       fifo_din,
   output logic             fifo_wr_en,
   output logic             busy,
   output logic             done,
   output logic             overflow,
   output logic [CNT_W-1:0] byte_count
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      FLUSH,
      DONE
   } state_t;

   state_t           state;
   state_t           nxt;
   logic [CNT_W-1:0] rem;
   logic [2:0]       bcnt;
   logic [7:0]       sr;
   logic [7:0]       shift_nxt;
   logic [7:0]       pad;
   logic [3:0]       fill;
   logic             samp;
   logic             wr_try;

   always_comb begin
      nxt    = state;
      samp   = 1'b0;
      wr_try = 1'b0;
      fill   = {1'b0, bcnt} + 4'd1;
      // pad shifts the collected bits into place and zero-fills the rest
      if (MSB_FIRST != 0) begin
         shift_nxt = {sr[6:0], data_in};
         pad       = shift_nxt << (4'd8 - fill);
      end else begin
         shift_nxt = {data_in, sr[7:1]};
         pad       = shift_nxt >> (4'd8 - fill);
      end
      unique case (state)
         IDLE: begin
            if (start)
               nxt = (nbits == '0) ? DONE : SHIFT;
         end
         SHIFT: begin
            if (rem != '0) begin
               samp   = 1'b1;
               wr_try = (fill == 4'd8) || (rem == CNT_W'(1));
               if (rem == CNT_W'(1) && fill != 4'd8)
                  nxt = FLUSH;
            end else begin
               nxt = DONE;
            end
         end
         FLUSH:   nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
      if (abort && state != IDLE) begin
         nxt    = IDLE;
         samp   = 1'b0;
         wr_try = 1'b0;
      end
   end

   always_ff @(posedge clk_5 or negedge Reset) begin
      if (!Reset)
         state <= IDLE;
      else
         state <= nxt;
   end

   always_ff @(posedge clk_5 or negedge Reset) begin
      if (!Reset) begin
         rem        <= '0;
         bcnt       <= '0;
         sr         <= '0;
         fifo_din   <= '0;
         fifo_wr_en <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         overflow   <= 1'b0;
         byte_count <= '0;
      end else begin
         busy       <= (nxt != IDLE);
         done       <= (nxt == DONE);
         fifo_wr_en <= wr_try && !fifo_full;
         if (state == IDLE && start) begin
            rem        <= nbits;
            bcnt       <= '0;
            sr         <= '0;
            byte_count <= '0;
            overflow   <= 1'b0;
         end
         if (samp) begin
            sr   <= shift_nxt;
            rem  <= rem - CNT_W'(1);
            bcnt <= bcnt + 3'd1;
         end
         if (wr_try) begin
            if (fifo_full) begin
               overflow <= 1'b1;
            end else begin
               fifo_din   <= pad;
               byte_count <= byte_count + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_data_deserializer.sv
// Directed bench for data_deserializer with a byte scoreboard that is
// filled as bits are driven and drained on every FIFO write.
`timescale 1ns/1ps
module tb_data_deserializer;

   logic        clk_5 = 1'b0;
   logic        Reset = 1'b0;
   logic        data_in = 1'b0;
   logic        start = 1'b0;
   logic [15:0] nbits = '0;
   logic        abort = 1'b0;
   logic        fifo_full = 1'b0;
   logic [7:0]  fifo_din;
   logic        fifo_wr_en;
   logic        busy;
   logic        done;
   logic        overflow;
   logic [15:0] byte_count;

   int          vectors = 0;
   int          miscompares = 0;
   int          done_cnt = 0;
   int          wr_cnt = 0;
   int          exp_done = 0;
   int          wr_snap;
   logic [7:0]  sb[$];

   data_deserializer #(.CNT_W(16), .MSB_FIRST(1)) dut (
      .clk_5      (clk_5),
      .Reset      (Reset),
      .data_in    (data_in),
      .start      (start),
      .nbits      (nbits),
      .abort      (abort),
      .fifo_full  (fifo_full),
      .fifo_din   (fifo_din),
      .fifo_wr_en (fifo_wr_en),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow),
      .byte_count (byte_count)
   );

   always #100 clk_5 = ~clk_5;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // scoreboard drain: every write must match the oldest queued byte
   always begin
      @(posedge clk_5);
      #1;
      if (done) done_cnt++;
      if (fifo_wr_en) begin
         wr_cnt++;
         chk("wr_while_full", {31'd0, fifo_full}, 32'd0);
         if (sb.size() == 0)
            chk("stray_write", {24'd0, fifo_din}, 32'hFFFF_FFFF);
         else
            chk("fifo_byte", {24'd0, fifo_din}, {24'd0, sb.pop_front()});
      end
   end

   task automatic start_rd(input int n);
      nbits = n[15:0];
      start = 1'b1;
      @(negedge clk_5);
      start = 1'b0;
   endtask

   task automatic send_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         data_in = v[i];
         @(negedge clk_5);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk_5);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_wr", {31'd0, fifo_wr_en}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      chk("rst_cnt", {16'd0, byte_count}, 32'd0);
      chk("rst_din", {24'd0, fifo_din}, 32'd0);
      Reset = 1'b1;
      repeat (2) @(negedge clk_5);

      // 16 bits: A5 then 3C
      sb.push_back(8'hA5);
      sb.push_back(8'h3C);
      start_rd(16);
      chk("t1_busy", {31'd0, busy}, 32'd1);
      send_bits(32'hA5, 8);
      chk("t1_wr1", {31'd0, fifo_wr_en}, 32'd1);
      chk("t1_din1", {24'd0, fifo_din}, 32'hA5);
      send_bits(32'h3C, 8);
      chk("t1_wr2", {31'd0, fifo_wr_en}, 32'd1);
      chk("t1_din2", {24'd0, fifo_din}, 32'h3C);
      chk("t1_nodone", {31'd0, done}, 32'd0);
      @(negedge clk_5);
      chk("t1_done", {31'd0, done}, 32'd1);
      @(negedge clk_5);
      exp_done++;
      chk("t1_idle", {31'd0, busy}, 32'd0);
      chk("t1_cnt", {16'd0, byte_count}, 32'd2);
      chk("t1_ndone", done_cnt, exp_done);

      // 11 bits, trailing byte zero-padded
      sb.push_back(8'hF0);
      sb.push_back(8'hA0);
      start_rd(11);
      send_bits(32'h785, 11);
      chk("t2_flush_wr", {31'd0, fifo_wr_en}, 32'd1);
      chk("t2_flush_din", {24'd0, fifo_din}, 32'hA0);
      @(negedge clk_5);
      chk("t2_done", {31'd0, done}, 32'd1);
      @(negedge clk_5);
      exp_done++;
      chk("t2_cnt", {16'd0, byte_count}, 32'd2);
      chk("t2_ndone", done_cnt, exp_done);

      // 24 bits, FIFO full for the second byte
      sb.push_back(8'h11);
      sb.push_back(8'h33);
      start_rd(24);
      send_bits(32'h11, 8);
      send_bits(32'h11, 7);
      fifo_full = 1'b1;
      send_bits(32'h0, 1);
      chk("t3_suppress", {31'd0, fifo_wr_en}, 32'd0);
      chk("t3_ovf", {31'd0, overflow}, 32'd1);
      chk("t3_cnt_hold", {16'd0, byte_count}, 32'd1);
      fifo_full = 1'b0;
      send_bits(32'h33, 8);
      chk("t3_wr3", {31'd0, fifo_wr_en}, 32'd1);
      repeat (2) @(negedge clk_5);
      exp_done++;
      chk("t3_cnt", {16'd0, byte_count}, 32'd2);
      chk("t3_ovf_sticky", {31'd0, overflow}, 32'd1);

      // zero-length request
      wr_snap = wr_cnt;
      start_rd(0);
      chk("t4_done", {31'd0, done}, 32'd1);
      chk("t4_ovf_clr", {31'd0, overflow}, 32'd0);
      chk("t4_cnt_clr", {16'd0, byte_count}, 32'd0);
      @(negedge clk_5);
      exp_done++;
      chk("t4_idle", {31'd0, busy}, 32'd0);
      chk("t4_nowr", wr_cnt, wr_snap);
      chk("t4_ndone", done_cnt, exp_done);

      // abort after 12 of 32 bits, then a fresh 8-bit readout
      sb.push_back(8'hC3);
      start_rd(32);
      send_bits(32'hC3, 8);
      send_bits(32'h5, 4);
      abort = 1'b1;
      @(negedge clk_5);
      abort = 1'b0;
      chk("t5_busy", {31'd0, busy}, 32'd0);
      chk("t5_cnt", {16'd0, byte_count}, 32'd1);
      repeat (2) @(negedge clk_5);
      chk("t5_nodone", done_cnt, exp_done);
      sb.push_back(8'h96);
      start_rd(8);
      send_bits(32'h96, 8);
      chk("t5_wr", {31'd0, fifo_wr_en}, 32'd1);
      chk("t5_din", {24'd0, fifo_din}, 32'h96);
      @(negedge clk_5);
      chk("t5_done", {31'd0, done}, 32'd1);
      @(negedge clk_5);
      exp_done++;
      chk("t5_cnt2", {16'd0, byte_count}, 32'd1);

      // abort lands on the same edge as an 8th bit
      start_rd(16);
      send_bits(32'h3B, 7);
      data_in = 1'b1;
      abort = 1'b1;
      @(negedge clk_5);
      abort = 1'b0;
      chk("t5b_nowr", {31'd0, fifo_wr_en}, 32'd0);
      chk("t5b_busy", {31'd0, busy}, 32'd0);
      chk("t5b_cnt", {16'd0, byte_count}, 32'd0);
      repeat (2) @(negedge clk_5);
      chk("t5b_ndone", done_cnt, exp_done);

      // asynchronous reset mid-readout
      sb.push_back(8'hFF);
      start_rd(16);
      send_bits(32'hFF, 8);
      send_bits(32'h7, 3);
      #20;
      Reset = 1'b0;
      #1;
      chk("t6_busy", {31'd0, busy}, 32'd0);
      chk("t6_din", {24'd0, fifo_din}, 32'd0);
      chk("t6_cnt", {16'd0, byte_count}, 32'd0);
      chk("t6_wr", {31'd0, fifo_wr_en}, 32'd0);
      repeat (3) @(negedge clk_5);
      Reset = 1'b1;
      repeat (4) @(negedge clk_5);
      chk("t6_quiet", {31'd0, busy}, 32'd0);
      sb.push_back(8'h5A);
      start_rd(8);
      send_bits(32'h5A, 8);
      chk("t6_wr_new", {31'd0, fifo_wr_en}, 32'd1);
      repeat (2) @(negedge clk_5);
      exp_done++;
      chk("t6_cnt_new", {16'd0, byte_count}, 32'd1);
      chk("t6_ndone", done_cnt, exp_done);
      chk("sb_empty", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
